tmr_recovery_ctrl: RTL and testbench

- Sequencer that recovers the triple-redundant CPU cluster after a TMR voter mismatch.
- Flow: halts all harts, waits for every halt acknowledge, splits the bus so each hart resynchronises its state, then recombines the cluster onto the single voted bus.
- Sits beside the voter and the safe-mode control FSM inside the safe CPU wrapper.
- Outputs merge (OR) into each hart's debug request, sync interrupt line and the single-bus select.

---
 rtl/cei_mochila_pkg.sv | 18 +
 rtl/tmr_rec_timer.sv | 45 ++++
 rtl/tmr_recovery_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_tmr_recovery_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cei_mochila_pkg.sv
// Shared types and defaults for the safe CPU wrapper recovery logic.
//   tmr_rec_state_e   : recovery sequencer state encoding (3-bit)
//   TMR_REC_TIMEOUT   : default cycle budget for WAIT_ACK / RESYNC phases
//   TMR_REC_MAX_RETRY : default resync attempts before giving up
package cei_mochila_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HALT    = 3'd1,
      RESYNC  = 3'd2,
      RELEASE = 3'd3,
      FAULT   = 3'd4
   } tmr_rec_state_e;

   localparam int unsigned TMR_REC_TIMEOUT   = 1024;
   localparam int unsigned TMR_REC_MAX_RETRY = 3;

endpackage

// File: rtl/tmr_rec_timer.sv
// Phase timeout counter for the recovery sequencer.
// Counts enabled cycles from 0 and holds at LIMIT-1, where expired_o is high.
// The holding compare sits ahead of the increment so the count never wraps.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : reload the count to 0 (wins over en_i)
//   en_i          : count this cycle
//   expired_o     : count has reached LIMIT-1
module tmr_rec_timer
   import cei_mochila_pkg::*;
#(
   parameter int unsigned LIMIT = TMR_REC_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] TERM = W'(LIMIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// TMR cluster recovery sequencer: on a voter mismatch it halts all harts,
// waits for their halt acks, splits the bus so each hart resynchronises,
// then recombines the cluster on the voted single bus.
// Optional build macro TMR_RECOVERY_LAT_EN adds last_lat_o (HALT-entry to
// RELEASE latency of the last successful recovery, saturating).
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   enable_i           : safe mode active; low aborts to IDLE
//   voter_error_i      : voter mismatch (level), acted on only in IDLE
//   error_id_i         : faulty hart mask, captured at trigger
//   halt_ack_i         : per-hart halted acknowledge
//   resync_done_i      : per-hart context restore complete
//   clr_cnt_i          : clears err_count_o
//   halt_req_o         : per-hart halt request
//   sync_intr_o        : per-hart resync interrupt
//   single_bus_o       : 1 = voted single bus, 0 = split buses
//   busy_o, fault_o    : recovery in progress / unrecoverable fault
//   err_count_o        : saturating count of completed recoveries
//   last_err_id_o      : error_id_i captured at the last trigger
//   last_lat_o         : (TMR_RECOVERY_LAT_EN only) last recovery latency
//
// state   | meaning
// IDLE    | waiting for a voter mismatch, bus follows enable_i
// HALT    | requesting halt, waiting for all acks
// RESYNC  | split buses, harts restoring context
// RELEASE | one cycle recombining on the voted bus, count bumped
// FAULT   | gave up; harts held halted until enable_i drops
module tmr_recovery_ctrl
   import cei_mochila_pkg::*;
#(
   parameter int unsigned NHARTS         = 3,
   parameter int unsigned TIMEOUT_CYCLES = TMR_REC_TIMEOUT,
   parameter int unsigned MAX_RETRY      = TMR_REC_MAX_RETRY,
   parameter int unsigned CNT_W          = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              voter_error_i,
   input  logic [NHARTS-1:0] error_id_i,
   input  logic [NHARTS-1:0] halt_ack_i,
   input  logic [NHARTS-1:0] resync_done_i,
   input  logic              clr_cnt_i,
   output logic [NHARTS-1:0] halt_req_o,
   output logic [NHARTS-1:0] sync_intr_o,
   output logic              single_bus_o,
   output logic              busy_o,
   output logic              fault_o,
   output logic [CNT_W-1:0]  err_count_o,
   output logic [NHARTS-1:0] last_err_id_o
`ifdef TMR_RECOVERY_LAT_EN
   ,
   output logic [15:0]       last_lat_o
`endif
);

   // retry+1 == MAX_RETRY is evaluated as retry == MAX_RETRY-1
   localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

   tmr_rec_state_e    state_q, state_d;
   logic [3:0]        retry_q, retry_d;
   logic [NHARTS-1:0] halt_req_q, halt_req_d;
   logic [NHARTS-1:0] sync_intr_q, sync_intr_d;
   logic              single_bus_q, single_bus_d;
   logic              busy_q, busy_d;
   logic              fault_q, fault_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic [NHARTS-1:0] last_err_id_q, last_err_id_d;
   logic              tmr_exp;
   logic              tmr_clr;
   logic              tmr_en;

   assign tmr_clr = (state_d != state_q);
   assign tmr_en  = (state_q == HALT) || (state_q == RESYNC);

   tmr_rec_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_exp)
   );

   always_comb begin
      state_d       = state_q;
      retry_d       = retry_q;
      last_err_id_d = last_err_id_q;
      case (state_q)
         IDLE: begin
            retry_d = '0;
            if (voter_error_i && enable_i) begin
               state_d       = HALT;
               last_err_id_d = error_id_i;
            end
         end
         HALT: begin
            if (&halt_ack_i) begin
               state_d = RESYNC;
            end else if (tmr_exp) begin
               state_d = FAULT;
            end
         end
         RESYNC: begin
            // completion beats a coincident timeout
            if (&resync_done_i) begin
               state_d = RELEASE;
            end else if (tmr_exp) begin
               retry_d = retry_q + 4'd1;
               state_d = (retry_q == RETRY_LAST) ? FAULT : HALT;
            end
         end
         RELEASE: state_d = IDLE;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
      if (!enable_i && (state_q != IDLE)) begin
         state_d = IDLE;
         retry_d = '0;
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      halt_req_d   = '0;
      sync_intr_d  = '0;
      single_bus_d = 1'b0;
      busy_d       = 1'b0;
      fault_d      = 1'b0;
      case (state_d)
         IDLE:    single_bus_d = enable_i;
         HALT: begin
            halt_req_d   = ~halt_ack_i;
            single_bus_d = 1'b1;
            busy_d       = 1'b1;
         end
         RESYNC: begin
            sync_intr_d = ~resync_done_i;
            busy_d      = 1'b1;
         end
         RELEASE: begin
            single_bus_d = 1'b1;
            busy_d       = 1'b1;
         end
         FAULT: begin
            halt_req_d = '1;
            fault_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      err_count_d = err_count_q;
      if (clr_cnt_i) begin
         err_count_d = '0;
      end else if ((state_q == RELEASE) && (err_count_q != '1)) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         retry_q       <= '0;
         halt_req_q    <= '0;
         sync_intr_q   <= '0;
         single_bus_q  <= 1'b0;
         busy_q        <= 1'b0;
         fault_q       <= 1'b0;
         err_count_q   <= '0;
         last_err_id_q <= '0;
      end else begin
         state_q       <= state_d;
         retry_q       <= retry_d;
         halt_req_q    <= halt_req_d;
         sync_intr_q   <= sync_intr_d;
         single_bus_q  <= single_bus_d;
         busy_q        <= busy_d;
         fault_q       <= fault_d;
         err_count_q   <= err_count_d;
         last_err_id_q <= last_err_id_d;
      end
   end

   assign halt_req_o    = halt_req_q;
   assign sync_intr_o   = sync_intr_q;
   assign single_bus_o  = single_bus_q;
   assign busy_o        = busy_q;
   assign fault_o       = fault_q;
   assign err_count_o   = err_count_q;
   assign last_err_id_o = last_err_id_q;

`ifdef TMR_RECOVERY_LAT_EN
   logic [15:0] lat_cnt_q, lat_cnt_d;
   logic [15:0] last_lat_q, last_lat_d;

   // Counts HALT/RESYNC cycles of the current recovery, retries included.
   always_comb begin
      lat_cnt_d  = lat_cnt_q;
      last_lat_d = last_lat_q;
      if ((state_q == IDLE) && (state_d == HALT)) begin
         lat_cnt_d = '0;
      end else if (((state_q == HALT) || (state_q == RESYNC)) && (lat_cnt_q != 16'hFFFF)) begin
         lat_cnt_d = lat_cnt_q + 16'd1;
      end
      if (state_q == RELEASE) begin
         last_lat_d = lat_cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lat_cnt_q  <= '0;
         last_lat_q <= '0;
      end else begin
         lat_cnt_q  <= lat_cnt_d;
         last_lat_q <= last_lat_d;
      end
   end

   assign last_lat_o = last_lat_q;
`endif

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Self-checking bench for tmr_recovery_ctrl (NHARTS=3, TIMEOUT_CYCLES=16,
// MAX_RETRY=3, CNT_W=2). Inputs change 1 time unit after the rising edge,
// outputs are sampled at the same point.
module tb_tmr_recovery_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       voter_error = 1'b0;
   logic       clr_cnt = 1'b0;
   logic [2:0] error_id = '0;
   logic [2:0] halt_ack = '0;
   logic [2:0] resync_done = '0;
   logic [2:0] halt_req;
   logic [2:0] sync_intr;
   logic       single_bus;
   logic       busy;
   logic       fault;
   logic [1:0] err_count;
   logic [2:0] last_err_id;
`ifdef TMR_RECOVERY_LAT_EN
   logic [15:0] last_lat;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tmr_recovery_ctrl #(
      .NHARTS         (3),
      .TIMEOUT_CYCLES (16),
      .MAX_RETRY      (3),
      .CNT_W          (2)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .enable_i      (enable),
      .voter_error_i (voter_error),
      .error_id_i    (error_id),
      .halt_ack_i    (halt_ack),
      .resync_done_i (resync_done),
      .clr_cnt_i     (clr_cnt),
      .halt_req_o    (halt_req),
      .sync_intr_o   (sync_intr),
      .single_bus_o  (single_bus),
      .busy_o        (busy),
      .fault_o       (fault),
      .err_count_o   (err_count),
      .last_err_id_o (last_err_id)
`ifdef TMR_RECOVERY_LAT_EN
      ,
      .last_lat_o    (last_lat)
`endif
   );

   typedef struct {
      logic       en;
      logic       ve;
      logic [2:0] id;
      logic [2:0] ack;
      logic [2:0] done;
      logic [2:0] hr;
      logic [2:0] si;
      logic       sb;
      logic       bz;
      logic       ft;
      logic [1:0] cnt;
      logic [2:0] lid;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(logic en, logic ve, logic [2:0] id, logic [2:0] ack,
                               logic [2:0] done, logic [2:0] hr, logic [2:0] si,
                               logic sb, logic bz, logic ft, logic [1:0] cnt,
                               logic [2:0] lid);
      vec_t v;
      v.en = en; v.ve = ve; v.id = id; v.ack = ack; v.done = done;
      v.hr = hr; v.si = si; v.sb = sb; v.bz = bz; v.ft = ft;
      v.cnt = cnt; v.lid = lid;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] hr, input logic [2:0] si,
                          input logic sb, input logic bz, input logic ft);
      chk({tag, ".halt_req"}, 32'(halt_req), 32'(hr));
      chk({tag, ".sync_intr"}, 32'(sync_intr), 32'(si));
      chk({tag, ".single_bus"}, 32'(single_bus), 32'(sb));
      chk({tag, ".busy"}, 32'(busy), 32'(bz));
      chk({tag, ".fault"}, 32'(fault), 32'(ft));
   endtask

   // Fast recovery: trigger, ack, done, then one RELEASE cycle.
   task automatic do_recovery(input logic clr_at_release);
      voter_error = 1'b1; error_id = 3'b010; step();
      voter_error = 1'b0; halt_ack = 3'b111; step();
      halt_ack = 3'b000; resync_done = 3'b111; step();
      chk("rel.single_bus", 32'(single_bus), 32'd1);
      chk("rel.busy", 32'(busy), 32'd1);
      resync_done = 3'b000; clr_cnt = clr_at_release; step();
      clr_cnt = 1'b0;
   endtask

   initial begin
      int n;
      int passes;
      int lat_exp;
      logic [2:0] prev_si;

      //      en ve id      ack     done    hr      si      sb bz ft cnt lid
      vecs[0]  = mk(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000);
      vecs[1]  = mk(1, 1, 3'b010, 3'b000, 3'b000, 3'b111, 3'b000, 1, 1, 0, 0, 3'b010);
      vecs[2]  = mk(1, 0, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 1, 1, 0, 0, 3'b010);
      vecs[3]  = mk(1, 0, 3'b000, 3'b001, 3'b000, 3'b110, 3'b000, 1, 1, 0, 0, 3'b010);
      vecs[4]  = mk(1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0, 3'b010);
      vecs[5]  = mk(1, 1, 3'b101, 3'b111, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0, 3'b010);
      vecs[6]  = mk(1, 0, 3'b000, 3'b111, 3'b010, 3'b000, 3'b101, 0, 1, 0, 0, 3'b010);
      vecs[7]  = mk(1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0, 3'b010);
      vecs[8]  = mk(1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0, 3'b010);
      vecs[9]  = mk(1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0, 3'b010);
      vecs[10] = mk(1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 0, 1, 0, 0, 3'b010);
      vecs[11] = mk(1, 0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 1, 1, 0, 0, 3'b010);
      vecs[12] = mk(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 1, 3'b010);
      vecs[13] = mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b010);

      // reset with enable and voter_error high must still give all zeros
      rst_n = 1'b0; enable = 1'b1; voter_error = 1'b1; error_id = 3'b111;
      step(); step();
      chk_out("reset", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      chk("reset.err_count", 32'(err_count), 32'd0);
      chk("reset.last_err_id", 32'(last_err_id), 32'd0);
      rst_n = 1'b1;

      // clean recovery, cycle by cycle
      lat_exp = -1;
      for (int i = 0; i < 14; i++) begin
         enable = vecs[i].en; voter_error = vecs[i].ve; error_id = vecs[i].id;
         halt_ack = vecs[i].ack; resync_done = vecs[i].done;
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].hr, vecs[i].si, vecs[i].sb, vecs[i].bz, vecs[i].ft);
         chk($sformatf("vec%0d.err_count", i), 32'(err_count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d.last_err_id", i), 32'(last_err_id), 32'(vecs[i].lid));
         if (vecs[i].bz) lat_exp++;
      end
`ifdef TMR_RECOVERY_LAT_EN
      chk("latency", 32'(last_lat), 32'(lat_exp));
`endif

      // halt acks already complete on the HALT entry edge; then done wins
      // over a coincident RESYNC timeout
      enable = 1'b1; voter_error = 1'b1; error_id = 3'b100; halt_ack = 3'b111; step();
      chk_out("ack_at_entry", 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
      voter_error = 1'b0; step();
      chk_out("ack_at_entry.resync", 3'b000, 3'b111, 1'b0, 1'b1, 1'b0);
      halt_ack = 3'b000;
      for (int k = 0; k < 15; k++) step();
      chk_out("done_vs_timeout.pre", 3'b000, 3'b111, 1'b0, 1'b1, 1'b0);
      resync_done = 3'b111; step();
      chk_out("done_vs_timeout", 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
      resync_done = 3'b000; step();
      chk("done_vs_timeout.err_count", 32'(err_count), 32'd2);

      // halt timeout: acks stuck at 011
      voter_error = 1'b1; error_id = 3'b001; halt_ack = 3'b011; step();
      voter_error = 1'b0;
      chk("halt_to.partial_req", 32'(halt_req), 32'b100);
      n = 0;
      while (!fault && n < 40) begin step(); n++; end
      chk("halt_to.cycles", 32'(n), 32'd16);
      chk_out("halt_to.fault", 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);
      step(); step(); step();
      chk("halt_to.sticky", 32'(fault), 32'd1);
      enable = 1'b0; step();
      chk_out("halt_to.exit", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      enable = 1'b1; halt_ack = 3'b000; step();

      // retry exhaustion: resync never completes
      voter_error = 1'b1; error_id = 3'b010; step();
      voter_error = 1'b0; halt_ack = 3'b111;
      n = 0; passes = 0; prev_si = '0;
      while (!fault && n < 200) begin
         step(); n++;
         if (sync_intr != 3'b000 && prev_si == 3'b000) passes++;
         prev_si = sync_intr;
      end
      chk("retry.passes", 32'(passes), 32'd3);
      chk("retry.cycles", 32'(n), 32'd51);
      chk("retry.fault", 32'(fault), 32'd1);
      chk("retry.err_count", 32'(err_count), 32'd2);
      enable = 1'b0; step();
      enable = 1'b1; halt_ack = 3'b000; step();

      // masking and abort
      voter_error = 1'b1; error_id = 3'b001; step();
      voter_error = 1'b0; halt_ack = 3'b111; step();
      voter_error = 1'b1; error_id = 3'b110; step();
      voter_error = 1'b0;
      chk("mask.last_err_id", 32'(last_err_id), 32'b001);
      chk_out("mask.resync", 3'b000, 3'b111, 1'b0, 1'b1, 1'b0);
      enable = 1'b0; step();
      chk_out("abort", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      enable = 1'b1; halt_ack = 3'b000; step(); step();
      chk_out("abort.no_restart", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);

      // saturation then clear-wins
      do_recovery(1'b0);
      chk("sat.3", 32'(err_count), 32'd3);
      do_recovery(1'b0);
      chk("sat.hold", 32'(err_count), 32'd3);
      do_recovery(1'b1);
      chk("clr_wins", 32'(err_count), 32'd0);

      // reset mid-recovery
      do_recovery(1'b0);
      chk("pre_reset.err_count", 32'(err_count), 32'd1);
      voter_error = 1'b1; error_id = 3'b100; step();
      voter_error = 1'b0; halt_ack = 3'b001; step();
      rst_n = 1'b0; step();
      chk_out("mid_reset", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      chk("mid_reset.err_count", 32'(err_count), 32'd0);
      chk("mid_reset.last_err_id", 32'(last_err_id), 32'd0);
      rst_n = 1'b1; halt_ack = 3'b000; step();
      chk_out("post_reset", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
